// File: rtl/run_ctrl_if.sv
// run_ctrl_if: start/done handshake and core-control signals of the launch sequencer.
interface run_ctrl_if #(parameter int CNT_W = 16);
    logic             start;
    logic             halt;
    logic             pc_rst;
    logic             run_en;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    modport master (output start, halt, input pc_rst, run_en, done, timeout, cycle_cnt);
    modport slave  (input start, halt, output pc_rst, run_en, done, timeout, cycle_cnt);
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: program-launch sequencer; holds the core idle until start falls,
// runs it until halt or watchdog expiry, and reports the run's cycle count.
module run_ctrl #(
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 60000
) (
    input  logic         clk,
    input  logic         rst_n,
    run_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, ARMED, RUN, DONE, TMO} state_t;
    state_t           state_q, state_d;
    logic             start_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pc_rst_q, run_en_q, done_q, tmo_q;
    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  state_d = bus.start ? ARMED : IDLE;
            ARMED: begin
                state_d = (start_q && !bus.start) ? RUN : ARMED;
                cnt_d   = (start_q && !bus.start) ? '0 : cnt_q;
            end
            RUN: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = bus.halt ? DONE : (cnt_q == CNT_W'(MAX_CYCLES - 1)) ? TMO : RUN;
            end
            DONE, TMO: state_d = bus.start ? ARMED : state_q;
            default:   state_d = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they are themselves registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            cnt_q    <= '0;
            pc_rst_q <= 1'b1;
            run_en_q <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= bus.start;
            cnt_q    <= cnt_d;
            pc_rst_q <= (state_d == IDLE) || (state_d == ARMED);
            run_en_q <= state_d == RUN;
            done_q   <= (state_d == DONE) || (state_d == TMO);
            tmo_q    <= state_d == TMO;
        end
    end
    assign bus.pc_rst    = pc_rst_q;
    assign bus.run_en    = run_en_q;
    assign bus.done      = done_q;
    assign bus.timeout   = tmo_q;
    assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized run lengths checked against a run-outcome model
// (halt cycle vs watchdog limit), plus reset, mid-run reset and ignored-input scenarios.
module tb_run_ctrl;
    localparam int CNT_W = 16;
    localparam int MAX   = 8;
    logic clk = 1'b0;
    logic rst_n;
    int   pass = 0;
    int   total = 0;
    run_ctrl_if #(.CNT_W(CNT_W)) bus ();
    run_ctrl #(.CNT_W(CNT_W), .MAX_CYCLES(MAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.halt = 1'b0;
        #12;
        total++;
        if ({bus.pc_rst, bus.run_en, bus.done, bus.timeout} !== 4'b1000)
            $display("FAIL reset_flags got=%b want=1000", {bus.pc_rst, bus.run_en, bus.done, bus.timeout});
        else pass++;
        total++;
        if (bus.cycle_cnt !== '0) $display("FAIL reset_cnt got=%0d want=0", bus.cycle_cnt);
        else pass++;
        rst_n = 1'b1;
        step();
    endtask
    // Model: a run with halt on RUN cycle h lasts min(h, MAX) cycles and times out iff h > MAX.
    task automatic do_run(input int h, input bit tog, input string tag);
        int  len;
        bit  exp_tmo;
        bit  exp_run;
        len = (h <= MAX) ? h : MAX;
        exp_tmo = h > MAX;
        bus.start = 1'b1;
        step();
        total++;
        if ({bus.pc_rst, bus.run_en, bus.done, bus.timeout} !== 4'b1000)
            $display("FAIL %s armed_flags got=%b want=1000", tag, {bus.pc_rst, bus.run_en, bus.done, bus.timeout});
        else pass++;
        bus.start = 1'b0;
        step();
        total++;
        if ({bus.pc_rst, bus.run_en} !== 2'b01)
            $display("FAIL %s launch got pc_rst,run_en=%b want=01", tag, {bus.pc_rst, bus.run_en});
        else pass++;
        for (int i = 1; i <= MAX + 2; i++) begin
            bus.halt = (i == h);
            if (tog) bus.start = (i == 2);
            step();
            bus.halt = 1'b0;
            exp_run = i < len;
            total++;
            if (bus.run_en !== exp_run)
                $display("FAIL %s run_en cycle %0d got=%b want=%b", tag, i, bus.run_en, exp_run);
            else pass++;
            if (!exp_run) break;
        end
        bus.start = 1'b0;
        total++;
        if ({bus.pc_rst, bus.done, bus.timeout} !== {2'b01, exp_tmo})
            $display("FAIL %s end_flags got=%b want=%b", tag, {bus.pc_rst, bus.done, bus.timeout}, {2'b01, exp_tmo});
        else pass++;
        total++;
        if (bus.cycle_cnt !== CNT_W'(len))
            $display("FAIL %s cycle_cnt got=%0d want=%0d", tag, bus.cycle_cnt, len);
        else pass++;
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        total++;
        if ({bus.done, bus.run_en} !== 2'b10 || bus.cycle_cnt !== CNT_W'(len))
            $display("FAIL %s hold_after_done got done,run_en=%b cnt=%0d want=10 cnt=%0d", tag, {bus.done, bus.run_en}, bus.cycle_cnt, len);
        else pass++;
    endtask
    task automatic test_halt_5th();
        do_run(5, 1'b0, "halt5");
    endtask
    task automatic test_watchdog();
        do_run(MAX + 5, 1'b0, "watchdog");
        do_run(MAX, 1'b0, "halt_at_limit");
        do_run(MAX - 1, 1'b0, "halt_below_limit");
    endtask
    task automatic test_reset_midrun();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.pc_rst, bus.run_en, bus.done, bus.timeout} !== 4'b1000 || bus.cycle_cnt !== '0)
            $display("FAIL midrun_reset got flags=%b cnt=%0d want=1000 cnt=0", {bus.pc_rst, bus.run_en, bus.done, bus.timeout}, bus.cycle_cnt);
        else pass++;
        #3 rst_n = 1'b1;
        step();
        step();
        total++;
        if ({bus.pc_rst, bus.run_en, bus.done} !== 3'b100)
            $display("FAIL idle_start_low got=%b want=100", {bus.pc_rst, bus.run_en, bus.done});
        else pass++;
        do_run(3, 1'b0, "after_reset");
    endtask
    task automatic test_back_to_back();
        do_run(2, 1'b0, "b2b_first");
        do_run(2, 1'b0, "b2b_second");
    endtask
    task automatic test_ignored();
        bus.start = 1'b1;
        bus.halt = 1'b1;
        step();
        step();
        bus.halt = 1'b0;
        total++;
        if ({bus.pc_rst, bus.run_en, bus.done} !== 3'b100)
            $display("FAIL halt_in_armed got=%b want=100", {bus.pc_rst, bus.run_en, bus.done});
        else pass++;
        do_run(6, 1'b1, "start_toggle");
    endtask
    task automatic test_random();
        for (int n = 0; n < 25; n++) do_run($urandom_range(1, MAX + 4), 1'($urandom_range(0, 1)), "random");
    endtask
    initial begin
        test_reset();
        test_halt_5th();
        test_watchdog();
        test_reset_midrun();
        test_back_to_back();
        test_ignored();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
